// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx through its ready/send handshake.
// Absorbs host bursts and drains one byte at a time while enabled.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          flush,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          busy,
    output logic [7:0]    tx_data,
    output logic          tx_send,
    input  logic          tx_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;
    logic            push;
    logic            drop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign busy    = (state != IDLE);
    assign tx_send = (state == SEND);

    // A pop frees a slot in the same cycle, so a write while full is still accepted.
    assign push = wr_en && !flush && (!full || pop);
    assign drop = wr_en && !flush && full && !pop;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (en && !empty && tx_ready && !flush) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!tx_ready) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)      tx_data <= 8'h00;
        else if (pop) tx_data <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; the bench plays the uart_tx ready handshake.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       flush;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_ready (tx_ready)
    );

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       flush;
        logic       clr_ovf;
        logic       ready;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
        logic       e_busy;
        logic       e_send;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic w, input logic [7:0] d,
                         input logic f, input logic c, input logic rdy);
        rst = r; en = e; wr_en = w; wr_data = d; flush = f; clr_ovf = c; tx_ready = rdy;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int waited;

        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        //            rst en wr data  fl clr rdy  cnt emp ful ovf bsy snd data
        vecs[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[1]  = '{1'b0,1'b1,1'b1,8'hAA,1'b0,1'b0,1'b1, 5'd1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[2]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd0,1'b1,1'b0,1'b0,1'b1,1'b1,8'hAA};
        vecs[3]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd0,1'b1,1'b0,1'b0,1'b1,1'b1,8'hAA};
        vecs[4]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 5'd0,1'b1,1'b0,1'b0,1'b1,1'b0,8'hAA};
        vecs[5]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 5'd0,1'b1,1'b0,1'b0,1'b1,1'b0,8'hAA};
        vecs[6]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd0,1'b1,1'b0,1'b0,1'b0,1'b0,8'hAA};
        vecs[7]  = '{1'b0,1'b0,1'b1,8'h11,1'b0,1'b0,1'b1, 5'd1,1'b0,1'b0,1'b0,1'b0,1'b0,8'hAA};
        vecs[8]  = '{1'b0,1'b0,1'b1,8'h22,1'b0,1'b0,1'b1, 5'd2,1'b0,1'b0,1'b0,1'b0,1'b0,8'hAA};
        vecs[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd2,1'b0,1'b0,1'b0,1'b0,1'b0,8'hAA};
        vecs[10] = '{1'b0,1'b1,1'b1,8'h33,1'b0,1'b0,1'b1, 5'd2,1'b0,1'b0,1'b0,1'b1,1'b1,8'h11};
        vecs[11] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 5'd2,1'b0,1'b0,1'b0,1'b1,1'b0,8'h11};
        vecs[12] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd2,1'b0,1'b0,1'b0,1'b0,1'b0,8'h11};
        vecs[13] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd1,1'b0,1'b0,1'b0,1'b1,1'b1,8'h22};
        vecs[14] = '{1'b0,1'b1,1'b1,8'h44,1'b1,1'b0,1'b1, 5'd0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h22};
        vecs[15] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 5'd0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h22};
        vecs[16] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h22};
        vecs[17] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b1, 5'd0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h22};

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].wr_en, vecs[i].wr_data,
                  vecs[i].flush, vecs[i].clr_ovf, vecs[i].ready);
            step();
            check($sformatf("v%0d.count", i),    32'(count),    32'(vecs[i].e_count));
            check($sformatf("v%0d.empty", i),    32'(empty),    32'(vecs[i].e_empty));
            check($sformatf("v%0d.full", i),     32'(full),     32'(vecs[i].e_full));
            check($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d.busy", i),     32'(busy),     32'(vecs[i].e_busy));
            check($sformatf("v%0d.tx_send", i),  32'(tx_send),  32'(vecs[i].e_send));
            check($sformatf("v%0d.tx_data", i),  32'(tx_data),  32'(vecs[i].e_data));
        end

        // Fill with the drain disabled, overflow with clr_ovf in the same cycle.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
            step();
            check($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
            check($sformatf("fill%0d.full", i),  32'(full),  32'(i == 15));
        end
        drive(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
        step();
        check("ovf_set.overflow", 32'(overflow), 32'd1);
        check("ovf_set.count",    32'(count),    32'd16);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        check("ovf_clr.overflow", 32'(overflow), 32'd0);

        // Write while full in the pop cycle.
        drive(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        step();
        check("fullpop.count",    32'(count),    32'd16);
        check("fullpop.overflow", 32'(overflow), 32'd0);
        check("fullpop.tx_send",  32'(tx_send),  32'd1);
        check("fullpop.tx_data",  32'(tx_data),  32'h10);
        wr_en = 1'b0;

        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(8'hEE);
        for (int k = 0; k < 17; k++) begin
            waited = 0;
            while (!tx_send && waited < 20) begin
                step();
                waited++;
            end
            check($sformatf("drain%0d.tx_send", k), 32'(tx_send), 32'd1);
            check($sformatf("drain%0d.tx_data", k), 32'(tx_data), 32'(exp_q[k]));
            tx_ready = 1'b0;
            step();
            tx_ready = 1'b1;
        end
        step(); step(); step();
        check("drained.empty",    32'(empty),    32'd1);
        check("drained.busy",     32'(busy),     32'd0);
        check("drained.count",    32'(count),    32'd0);
        check("drained.overflow", 32'(overflow), 32'd0);

        // Reset while SEND with a byte still queued.
        drive(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b0, 1'b1);
        step();
        check("pre_rst.tx_send", 32'(tx_send), 32'd1);
        check("pre_rst.tx_data", 32'(tx_data), 32'h5A);
        check("pre_rst.count",   32'(count),   32'd1);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        check("rst_send.tx_send", 32'(tx_send), 32'd0);
        check("rst_send.busy",    32'(busy),    32'd0);
        check("rst_send.count",   32'(count),   32'd0);
        check("rst_send.empty",   32'(empty),   32'd1);
        check("rst_send.tx_data", 32'(tx_data), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer that sits directly upstream of `uart_tx`: accepts bytes from the host side at clock rate and drains them one at a time into the transmitter using `uart_tx`'s `ready`/`send` handshake. Absorbs bursts so the host never has to wait on the slow UART bit clock. The FIFO storage, write-side status, overflow flag and a small drain state machine live here. Frame format (size, parity, stop bits) is configured directly on `uart_tx` and is not handled by this block.

## Interface
- `DEPTH`, 16, FIFO depth in bytes; power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`, derived pointer width; do not override.
- `clk` input 1: system clock; one clock domain for the whole block.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: drain enable; 0 stops new bytes from starting, but a byte already handed to `uart_tx` completes.
- `wr_data` input 8: byte to enqueue.
- `wr_en` input 1: enqueue strobe, one byte per cycle.
- `flush` input 1: discard all queued bytes.
- `clr_ovf` input 1: clears `overflow`.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `count` output AW+1: bytes queued, excluding any byte already handed to `uart_tx`.
- `overflow` output 1: sticky; a write was dropped.
- `busy` output 1: high when the state is not IDLE.
- `tx_data` output 8: to `uart_tx` data; held stable from SEND entry until the return to IDLE.
- `tx_send` output 1: to `uart_tx` send.
- `tx_ready` input 1: from `uart_tx` ready.

## Operation
- Storage: DEPTH×8 register array, with a write pointer, a read pointer and `count`. Pointers wrap modulo DEPTH.
- Write rules:
  - With `wr_en=1` and not full: store at `wr_ptr` and increment.
  - With `wr_en=1` and full: the byte is dropped and `overflow` is set. Exception: if a pop happens in the same cycle, the write is accepted and `count` is unchanged.
  - With write and pop in the same cycle and the FIFO not full: `count` is unchanged.
- `flush=1`: pointers and `count` go to 0 next cycle. A simultaneous `wr_en` is ignored and does not set `overflow`. A simultaneous pop is suppressed. An in-flight byte (SEND/WAIT_DONE) still completes.
- `overflow`: set by a dropped write, cleared by `clr_ovf`. If both happen in the same cycle, set wins.
- Drain FSM, states IDLE, SEND, WAIT_DONE:
  - IDLE: if `en & ~empty & tx_ready`, pop the head into the `tx_data` register and go to SEND.
  - SEND: `tx_send=1`. Stay until `tx_ready==0`, which is the transmitter's acceptance; then go to WAIT_DONE. `tx_send` is held rather than pulsed because `uart_tx` samples it on its slower baud clock.
  - WAIT_DONE: `tx_send=0`. When `tx_ready==1`, return to IDLE.
- `en` is sampled only in IDLE.
- Reset values: pointers 0, `count`=0, `full`=0, `empty`=1, `overflow`=0, state IDLE, `busy`=0, `tx_send`=0, `tx_data`=8'h00.
- Reset in any state returns to IDLE in one cycle and discards all data, including the in-flight byte. `uart_tx` shares `rst` and aborts its frame too.

## Timing
- All outputs are registered, and status reflects the previous cycle's operations.
- Latency with an empty FIFO, IDLE state and `tx_ready=1`:
  - `wr_en` in cycle 0.
  - `empty=0`, `count=1` in cycle 1.
  - `tx_send=1` and `tx_data` valid in cycle 2, with `count=0`.
- Minimum spacing between pops: SEND and WAIT_DONE each last at least 1 cycle, so a new byte can enter SEND at the earliest 1 cycle after `tx_ready` rises.
- Back-to-back `wr_en` for DEPTH cycles with the drain idle (`en=0`) gives `full=1` exactly DEPTH cycles after the first write.
- `busy` is asserted in the cycle SEND is entered and falls in the cycle IDLE is re-entered.

## Test plan
- Single byte: write 8'hAA with `uart_tx` attached (8N1, 76.8 kHz) → `tx_send` is high 2 cycles after the write and stays high until `ready` falls; `tx` carries the frame for 0xAA; `busy` falls after the stop bit.
- Burst: with `en=1`, write 0x01..0x05 on consecutive cycles → `count` peaks at 4; the serial output is 0x01..0x05 in order; `empty=1` and `busy=0` at the end; `overflow=0`.
- Fill and overflow (DEPTH=16): with `en=0`, write 17 bytes → `full=1` after the 16th write, `count=16`, the 17th byte is dropped and `overflow=1`. Then pulse `clr_ovf` → `overflow=0`. Set `en=1` → all 16 bytes are sent in order and the pointers wrap correctly.
- Write while full with a pop: with the FIFO full and the FSM entering SEND, write in the pop cycle → `count` stays 16 and `overflow` stays 0.
- Flush: queue 3 bytes during a transmission, then pulse `flush` with `wr_en` in the same cycle → `count=0`, `overflow=0`, the current byte completes, and no further `tx_send` occurs.
- Reset in SEND: assert `rst` for 1 cycle while `tx_send=1` → next cycle `tx_send=0`, IDLE state, `count=0`, `empty=1`, `tx_data=0x00`.
